// File: rtl/burst_bus_arbiter_pkg.sv
// Shared types and default sizing for the burst bus arbiter.
// FSM state encoding plus parameter defaults used by the interface and RTL.
package bus_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_OWN     = 2'd1,
      ST_RELEASE = 2'd2
   } arb_state_t;

   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_MAX_BURST = 16;
   localparam int DEF_TIMEOUT   = 255;

endpackage

// File: rtl/burst_bus_arbiter_if.sv
// Requester/target side of the burst arbiter: requests, beat handshake, grant status.
// master drives requests and acks; slave (the arbiter) drives grant and strobe.
interface burst_bus_arbiter_if
   import bus_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ
);
   localparam int ENC_W = $clog2(NUM_REQ) + 1;

   logic               ce;
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] last;
   logic               tgt_ack;
   logic [NUM_REQ-1:0] grant;
   logic [ENC_W-1:0]   grant_enc;
   logic               tgt_stb;
   logic               busy;
   logic               timeout_err;

   modport master (
      output ce, req, last, tgt_ack,
      input  grant, grant_enc, tgt_stb, busy, timeout_err
   );

   modport slave (
      input  ce, req, last, tgt_ack,
      output grant, grant_enc, tgt_stb, busy, timeout_err
   );

endinterface

// File: rtl/burst_bus_arbiter_rr_pick.sv
// Combinational round-robin winner: first requester above i_prev, wrapping.
// Zero latency; o_enc is all-ones when nobody requests.
module rr_pick
   import bus_arb_pkg::*;
#(
   parameter  int NUM_REQ = DEF_NUM_REQ,
   localparam int IW      = $clog2(NUM_REQ),
   localparam int ENC_W   = IW + 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IW-1:0]      i_prev,
   output logic [NUM_REQ-1:0] o_onehot,
   output logic [ENC_W-1:0]   o_enc
);

   logic          w_found;
   logic [IW-1:0] w_idx;

   // Offset NUM_REQ lands back on i_prev itself, so a lone previous owner can win again.
   always_comb begin
      o_onehot = '0;
      o_enc    = '1;
      w_found  = 1'b0;
      w_idx    = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         w_idx = IW'((int'(i_prev) + i) % NUM_REQ);
         if (!w_found && i_req[w_idx]) begin
            w_found         = 1'b1;
            o_onehot[w_idx] = 1'b1;
            o_enc           = ENC_W'(w_idx);
         end
      end
   end

endmodule

// File: rtl/burst_bus_arbiter.sv
// Round-robin burst arbiter: one-cycle grant latency, bounded bursts, watchdog release.
// ce low freezes all state; an owner stalls by holding req with no tgt_ack.
module burst_bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int MAX_BURST = DEF_MAX_BURST,
   parameter int TIMEOUT   = DEF_TIMEOUT
) (
   input  logic                clk,
   input  logic                rst,
   burst_bus_arbiter_if.slave  bus
);

   localparam int IW    = $clog2(NUM_REQ);
   localparam int ENC_W = IW + 1;
   localparam int BW    = $clog2(MAX_BURST + 1);
   localparam int WW    = $clog2(TIMEOUT + 1);

   arb_state_t         r_state;
   arb_state_t         w_state_nxt;
   logic [NUM_REQ-1:0] r_grant;
   logic [NUM_REQ-1:0] w_grant_nxt;
   logic [ENC_W-1:0]   r_grant_enc;
   logic [ENC_W-1:0]   w_grant_enc_nxt;
   logic [IW-1:0]      r_prev;
   logic [IW-1:0]      w_prev_nxt;
   logic [BW-1:0]      r_beats;
   logic [BW-1:0]      w_beats_nxt;
   logic [WW-1:0]      r_wdog;
   logic [WW-1:0]      w_wdog_nxt;

   logic [NUM_REQ-1:0] w_pick_onehot;
   logic [ENC_W-1:0]   w_pick_enc;
   logic [IW-1:0]      w_owner;
   logic               w_stb;
   logic               w_beat;
   logic [BW-1:0]      w_beats_inc;
   logic [WW-1:0]      w_wdog_inc;
   logic               w_burst_done;
   logic               w_wd_expire;
   logic               w_timeout_err;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .i_req    (bus.req),
      .i_prev   (r_prev),
      .o_onehot (w_pick_onehot),
      .o_enc    (w_pick_enc)
   );

   assign w_owner      = r_grant_enc[IW-1:0];
   assign w_stb        = (r_state == ST_OWN) && bus.req[w_owner];
   assign w_beat       = w_stb && bus.tgt_ack;
   assign w_beats_inc  = (r_beats == BW'(MAX_BURST)) ? r_beats : r_beats + 1'b1;
   assign w_wdog_inc   = (r_wdog == WW'(TIMEOUT)) ? r_wdog : r_wdog + 1'b1;
   assign w_burst_done = (w_beats_inc == BW'(MAX_BURST));
   // An ack landing on the expiry cycle wins over the watchdog.
   assign w_wd_expire  = (r_state == ST_OWN) && (r_wdog == WW'(TIMEOUT)) && !w_beat;

   always_comb begin
      w_state_nxt     = r_state;
      w_grant_nxt     = r_grant;
      w_grant_enc_nxt = r_grant_enc;
      w_prev_nxt      = r_prev;
      w_beats_nxt     = r_beats;
      w_wdog_nxt      = r_wdog;
      w_timeout_err   = 1'b0;
      if (bus.ce) begin
         unique case (r_state)
            ST_IDLE: begin
               if (|bus.req) begin
                  w_grant_nxt     = w_pick_onehot;
                  w_grant_enc_nxt = w_pick_enc;
                  w_beats_nxt     = '0;
                  w_wdog_nxt      = '0;
                  w_state_nxt     = ST_OWN;
               end
            end
            ST_OWN: begin
               if (w_beat) begin
                  w_beats_nxt = w_beats_inc;
                  w_wdog_nxt  = '0;
               end else begin
                  w_wdog_nxt  = w_wdog_inc;
               end
               if (!bus.req[w_owner] || w_wd_expire ||
                   (w_beat && (bus.last[w_owner] || w_burst_done))) begin
                  w_grant_nxt     = '0;
                  w_grant_enc_nxt = '1;
                  w_prev_nxt      = w_owner;
                  w_timeout_err   = w_wd_expire;
                  w_state_nxt     = ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               w_state_nxt = ST_IDLE;
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_grant     <= '0;
         r_grant_enc <= '1;
         r_prev      <= IW'(NUM_REQ - 1);
         r_beats     <= '0;
         r_wdog      <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_grant     <= w_grant_nxt;
         r_grant_enc <= w_grant_enc_nxt;
         r_prev      <= w_prev_nxt;
         r_beats     <= w_beats_nxt;
         r_wdog      <= w_wdog_nxt;
      end
   end

   assign bus.grant       = r_grant;
   assign bus.grant_enc   = r_grant_enc;
   assign bus.tgt_stb     = w_stb;
   assign bus.busy        = (r_state != ST_IDLE);
   assign bus.timeout_err = w_timeout_err;

endmodule
